// File: rtl/aes_pkg.sv
// Shared AES tables, typedefs and key-schedule helpers for the inverse cipher.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} aes_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        if (i < 4'd10) r = RCON[i];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (enough for 9, b, d, e).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // RotWord + SubWord + rcon on one key word.
    function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
        return {SBOX[w[23:16]] ^ rc, SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic aes_key_t key_fwd(input aes_key_t k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ key_g(k[31:0], rc);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic aes_key_t key_inv(input aes_key_t k, input logic [7:0] rc);
        logic [31:0] o0, o1, o2, o3;
        o3 = k[31:0] ^ k[63:32];
        o2 = k[63:32] ^ k[95:64];
        o1 = k[95:64] ^ k[127:96];
        o0 = k[127:96] ^ key_g(o3, rc);
        return {o0, o1, o2, o3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rkey,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] ark, mixed;

    // Byte i sits at row i%4, column i/4; row r was rotated left by r on encrypt.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = R + 4 * ((C - R + 4) % 4);
        assign ark[127-8*i -: 8] = INV_SBOX[state_in[127-8*SRC -: 8]] ^ rkey[127-8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = ark[127-32*c -: 32];
        assign mixed[127-32*c -: 32] = {
            gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
        };
    end

    assign state_out = last ? ark : mixed;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: expands to K10, then rewinds the schedule one
// round per cycle. Optional K10 cache enabled by defining AES_KEY_CACHE_EN.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);

    aes_state_t st, st_n;
    logic [3:0] cnt, cnt_n;
    aes_key_t   kreg, kreg_n, rk, k10c;
    aes_block_t blk, blk_n, rnd_out;
    logic       hit;

    assign rk = key_inv(kreg, rcon(cnt));

    aes_inv_round u_round (
        .state_in  (blk),
        .rkey      (rk),
        .last      (cnt == 4'd0),
        .state_out (rnd_out)
    );

`ifdef AES_KEY_CACHE_EN
    aes_key_t ckey;
    logic     cvld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ckey <= '0;
            k10c <= '0;
            cvld <= 1'b0;
        end else if (st == IDLE && in_valid && !hit) begin
            ckey <= key;
            cvld <= 1'b0;
        end else if (st == KEXP && cnt == 4'd10) begin
            k10c <= kreg;
            cvld <= 1'b1;
        end
    end

    assign hit = cvld && (key == ckey);
`else
    assign hit  = 1'b0;
    assign k10c = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            cnt  <= 4'd0;
            kreg <= '0;
            blk  <= '0;
        end else begin
            st   <= st_n;
            cnt  <= cnt_n;
            kreg <= kreg_n;
            blk  <= blk_n;
        end
    end

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        kreg_n = kreg;
        blk_n  = blk;
        case (st)
            IDLE: if (in_valid) begin
                st_n  = KEXP;
                blk_n = din;
                // A cache hit parks KEXP at K10 so only the load cycle remains.
                if (hit) begin
                    kreg_n = k10c;
                    cnt_n  = 4'd10;
                end else begin
                    kreg_n = key;
                    cnt_n  = 4'd0;
                end
            end
            KEXP: if (cnt == 4'd10) begin
                blk_n = blk ^ kreg;
                cnt_n = 4'd9;
                st_n  = ROUND;
            end else begin
                kreg_n = key_fwd(kreg, rcon(cnt));
                cnt_n  = cnt + 4'd1;
            end
            ROUND: begin
                blk_n  = rnd_out;
                kreg_n = rk;
                if (cnt == 4'd0) st_n = DONE;
                else             cnt_n = cnt - 4'd1;
            end
            DONE: if (out_ready) begin
                st_n  = IDLE;
                blk_n = '0;
            end
            default: st_n = IDLE;
        endcase
    end

    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign busy      = (st != IDLE);
    assign dout      = out_valid ? blk : '0;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed + random bench for aes_inv_cipher with an expected-plaintext scoreboard.
module tb_aes_inv_cipher;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] din, key, dout;

    int npass = 0;
    int ntot  = 0;
    logic [127:0] sbq[$];
    logic [7:0]   sb_t[256];

`ifdef AES_KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Independent reference: GF(2^8) arithmetic and a forward AES-128 encryptor.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] rk, s;
        logic [31:0]  g, w;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   b[16];
        logic [7:0]   o[16];
        rc = 8'h01; rk = k; s = pt ^ k;
        for (int r = 1; r <= 10; r++) begin
            w = rk[31:0];
            g = {sb_t[w[23:16]] ^ rc, sb_t[w[15:8]], sb_t[w[7:0]], sb_t[w[31:24]]};
            rk[127:96] = rk[127:96] ^ g;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = gm(rc, 8'h02);
            for (int i = 0; i < 16; i++) b[i] = sb_t[s[127-8*i -: 8]];
            for (int i = 0; i < 16; i++) o[i] = b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
                if (r < 10) begin
                    b[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    b[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end else begin
                    b[4*c] = a0; b[4*c+1] = a1; b[4*c+2] = a2; b[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i] ^ rk[127-8*i -: 8];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accepts one block, checks latency and plaintext, optionally stalls in DONE.
    task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                        input int lat, input int hold);
        int n;
        logic [127:0] exp, d0;
        chk("ready_before_accept", 128'(in_ready), 128'd1);
        sbq.push_back(pt);
        in_valid = 1'b1; din = ct; key = k;
        @(posedge clk); #1;
        // Junk inputs while busy must be ignored.
        din = ~ct; key = ~k;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 128'(n), 128'(lat));
        exp = sbq.pop_front();
        chk("dout", dout, exp);
        d0 = dout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_dout", dout, d0);
            chk("hold_valid", 128'(out_valid), 128'd1);
            chk("hold_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_dout", dout, 128'd0);
    endtask

    initial begin
        logic [7:0]   inv;
        logic [127:0] pt, k;
        int           seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0; key = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_dout", dout, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(C1_CT, C1_KEY, C1_PT, 21, 0);
`ifdef AES_KEY_CACHE_EN
        send(C1_CT, C1_KEY, C1_PT, HIT_LAT, 0);
`endif
        send(B_CT, B_KEY, B_PT, 21, 5);
        send(B_CT, B_KEY, B_PT, HIT_LAT, 0);

        // Abort a block in ROUND with an asynchronous reset.
        in_valid = 1'b1; din = C1_CT; key = C1_KEY;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("busy_mid_round", 128'(busy), 128'd1);
        rst = 1'b1;
        #2;
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_dout", dout, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("abort_no_output", 128'(seen), 128'd0);
        send(C1_CT, C1_KEY, C1_PT, 21, 0);

        for (int t = 0; t < 100; t++) begin
            pt = rnd128();
            k  = rnd128();
            send(enc(pt, k), k, pt, 21, 0);
        end

        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have clock/reset ports named clk and rst, with one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  ciphertext/key presented.
REQ-005 in_ready  output  1  block can accept a new ciphertext.
REQ-006 din  input  128  ciphertext; bits [127:120] = byte 0, column-major, same byte order as the encryptor.
REQ-007 key  input  128  AES-128 cipher key (round-0 key), same byte order.
REQ-008 out_valid  output  1  plaintext valid.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 dout  output  128  recovered plaintext.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL be a single-transform inverse cipher with the FSM states IDLE, KEXP, ROUND and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; acceptance = in_valid && in_ready on a rising edge, capturing din and key.
REQ-014 On acceptance, SHALL go to KEXP with round counter = 0.
REQ-015 KEXP SHALL advance the forward key schedule one round key per cycle (rcon 01,02,...,36) for 10 cycles, ending with round-10 key K10.
REQ-016 On the KEXP-to-ROUND transition, SHALL load state = captured ciphertext XOR K10 and counter = 9.
REQ-017 ROUND SHALL do one inverse round per cycle for r = 9 down to 0: InvShiftRows, InvSubBytes, XOR K_r, then InvMixColumns only when r != 0.
REQ-018 K_r SHALL be derived from K_(r+1) each cycle by the inverse key schedule; no 11-entry key RAM.
REQ-019 After round r = 0, SHALL enter DONE with dout = state and out_valid = 1.
REQ-020 Latency SHALL be exactly 21 cycles from the acceptance edge to out_valid high (10 KEXP + 10 ROUND + 1).
REQ-021 DONE SHALL hold dout and out_valid stable while out_ready = 0, then go to IDLE on the edge where out_ready = 1.
REQ-022 in_ready SHALL be 0 in DONE, so back-to-back throughput is 1 block per 22 cycles minimum.
REQ-023 in_valid asserted outside IDLE SHALL be ignored; din and key changes after acceptance SHALL have no effect.
REQ-024 dout SHALL be 0 in all states except DONE.

Reset
REQ-025 rst SHALL immediately force: state IDLE, in_ready = 1, out_valid = 0, busy = 0, dout = 0, counter = 0, and the key cache invalid.
REQ-026 rst asserted mid-KEXP/ROUND/DONE SHALL abort the block without emitting output; the first acceptance after release SHALL behave as after power-up.

Configuration
REQ-027 Macro AES_KEY_CACHE_EN defined: SHALL store the last accepted key and its K10 with a valid flag.
REQ-028 With AES_KEY_CACHE_EN, an acceptance whose key equals the cached valid key SHALL skip KEXP, go straight to ROUND (load as REQ-016), and give out_valid 11 cycles after acceptance.
REQ-029 AES_KEY_CACHE_EN undefined: no cache registers; every block SHALL run KEXP (21-cycle latency).

Structure
REQ-030 Shared package aes_pkg SHALL hold the S-box, inverse S-box, rcon table, the 128-bit state/key typedefs, and the FSM state enum.
REQ-031 SHALL instantiate one combinational sub-module aes_inv_round(state_in, rkey, last, state_out).
REQ-032 Key-step (forward/inverse) logic SHALL be package functions, not separate modules.

Verification
REQ-033 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, din 69c4e0d86a7b0430d8cdb78070b4c55a -> dout 00112233445566778899aabbccddeeff, exactly 21 cycles after acceptance.
REQ-034 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, din 3925841d02dc09fbdc118597196a0b32 -> dout 3243f6a8885a308d313198a2e0370734.
REQ-035 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> dout and out_valid stable and in_ready = 0 throughout; IDLE one edge after out_ready = 1.
REQ-036 Reset mid-ROUND (cycle 15 after acceptance) -> out_valid never asserts; the next C.1 vector completes correctly in 21 cycles.
REQ-037 AES_KEY_CACHE_EN: run C.1 twice with the same key -> second latency 11; then App. B key -> 21; reset then C.1 -> 21.
REQ-038 Round-trip: encryptor output for 100 random (pt, key) pairs fed to aes_inv_cipher -> dout equals pt every time.
